// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// CPU-side requester that sits between the MEM pipeline stage and DataMemory.
// It accepts a single-cycle load/store request from the pipeline and turns it
// into a held memory access. While the access is outstanding it stalls the
// pipeline. The load result is registered. Word accesses that are not 4-byte
// aligned are rejected without touching memory.
//
// Optional feature: define MAU_TIMEOUT_EN to compile in a watchdog. The
// watchdog aborts an access after TIMEOUT cycles in WAIT with no MemReady,
// returns 32'hDEADBEEF as load data, and pulses Timeout. Without the macro,
// WAIT lasts until MemReady arrives and Timeout is tied to 0.
//
// Parameters:
//   ND        nominal memory delay; documentation and bench memory model only
//   TIMEOUT   watchdog limit in WAIT cycles (2..31)
//
// Ports:
//   clk           clock; all state changes on the rising edge
//   reset         asynchronous reset, active low
//   ReqRead       load request, held by the pipeline while Stall=1
//   ReqWrite      store request, held by the pipeline while Stall=1
//                 (wins when both request lines are high)
//   ReqAddress    byte address of the request
//   ReqWriteData  store data
//   Stall         combinational pipeline freeze
//   LoadData      registered load result
//   MisalignErr   combinational; current request rejected (address[1:0] != 0)
//   Timeout       registered one-cycle pulse on watchdog abort
//   MemWrite      registered write strobe to DataMemory
//   Address       registered address to DataMemory
//   WriteData     registered store data to DataMemory
//   ReadData      read data from DataMemory
//   MemReady      access-complete flag from DataMemory
//   dbg_state     current FSM state (IDLE=0, WAIT=1, DONE=2)
//
// Handshake: a request is accepted on the rising edge that ends an IDLE cycle
// in which a request line is high, the address is aligned and reset is
// released. The pipeline keeps the request stable while Stall=1 and advances
// at the end of the first cycle with Stall=0 (the DONE cycle). On the memory
// side, MemReady completes the access on the edge it is sampled high, except
// in the first WAIT cycle, where it may still belong to the previous access.

module mem_access_unit #(
    parameter int ND      = 3,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqRead,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddress,
    input  logic [31:0] ReqWriteData,
    output logic        Stall,
    output logic [31:0] LoadData,
    output logic        MisalignErr,
    output logic        Timeout,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData,
    input  logic        MemReady,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    generate
        if (TIMEOUT < 2 || TIMEOUT > 31 || ND < 1) begin : g_param_check
            $error("mem_access_unit: TIMEOUT must be 2..31 and ND must be >= 1");
        end
    endgenerate

`ifdef MAU_TIMEOUT_EN
    // Abort on the edge that ends the TIMEOUT-th WAIT cycle.
    localparam logic [4:0] CNT_LIMIT = 5'(TIMEOUT - 1);
`endif

    state_t     state;
    logic [4:0] cnt;
    logic       req;
    logic       aligned;

    assign req       = ReqRead | ReqWrite;
    assign aligned   = (ReqAddress[1:0] == 2'b00);
    assign dbg_state = state;

    // Both outputs are forced low while reset is held.
    assign Stall       = reset & ((state == WAIT) | ((state == IDLE) & req & aligned));
    assign MisalignErr = reset & (state == IDLE) & req & ~aligned;

`ifndef MAU_TIMEOUT_EN
    assign Timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            MemWrite  <= 1'b0;
            Address   <= 32'd0;
            WriteData <= 32'd0;
            LoadData  <= 32'd0;
`ifdef MAU_TIMEOUT_EN
            Timeout   <= 1'b0;
`endif
        end else begin
`ifdef MAU_TIMEOUT_EN
            Timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req && aligned) begin
                        Address   <= ReqAddress;
                        WriteData <= ReqWriteData;
                        MemWrite  <= ReqWrite;
                        cnt       <= 5'd0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 5'd31) begin
                        cnt <= cnt + 5'd1;
                    end
                    // cnt==0 masks a MemReady still high from the prior access.
                    if (MemReady && (cnt != 5'd0)) begin
                        MemWrite <= 1'b0;
                        if (!MemWrite) begin
                            LoadData <= ReadData;
                        end
                        state <= DONE;
                    end
`ifdef MAU_TIMEOUT_EN
                    else if (cnt == CNT_LIMIT) begin
                        MemWrite <= 1'b0;
                        LoadData <= 32'hDEADBEEF;
                        Timeout  <= 1'b1;
                        state    <= DONE;
                    end
`endif
                end
                DONE: begin
                    // Requests seen here belong to the completing instruction.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// ------------------
// Bench for mem_access_unit. A pipeline-like driver issues load/store and
// misaligned requests; a DataMemory model answers with a per-access latency
// and can optionally leave MemReady high for a few cycles after completion.
// A reference model (word array + last load/address) predicts every response
// and pushes it into exp_q; a monitor pops and compares at each DONE cycle
// and each MisalignErr cycle.

`timescale 1ns/1ps

module tb_mem_access_unit;

    localparam int ND      = 3;
    localparam int TIMEOUT = 16;
    localparam int W       = 74;   // {is_err, tmo, stall[7:0], addr[31:0], load[31:0]}

    // ------------------------------------------------------------ clock/reset
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ DUT signals
    logic        req_read;
    logic        req_write;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        stall;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        timeout;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_ready;
    logic [1:0]  dbg_state;

    mem_access_unit #(.ND(ND), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .ReqRead      (req_read),
        .ReqWrite     (req_write),
        .ReqAddress   (req_address),
        .ReqWriteData (req_write_data),
        .Stall        (stall),
        .LoadData     (load_data),
        .MisalignErr  (misalign_err),
        .Timeout      (timeout),
        .MemWrite     (mem_write),
        .Address      (address),
        .WriteData    (write_data),
        .ReadData     (read_data),
        .MemReady     (mem_ready),
        .dbg_state    (dbg_state)
    );

    // ------------------------------------------------------------ memory model
    logic [31:0] mem [0:255];
    bit          mem_cleared = 1'b0;
    bit          kick;        // driver: an access is accepted at the next edge
    bit          stuck;       // MemReady never rises
    bit          stale_en;    // keep MemReady high a few cycles after completion
    bit          pending;
    int          mem_delay;
    int          lat;
    int          stale_left;

    assign read_data = mem[address[9:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!mem_cleared) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
                mem_cleared <= 1'b1;
            end
            pending    <= 1'b0;
            lat        <= 0;
            mem_ready  <= 1'b0;
            stale_left <= 0;
        end else if (kick) begin
            pending    <= 1'b1;
            lat        <= 1;
            mem_ready  <= (stale_left > 0);
            stale_left <= (stale_left > 0) ? stale_left - 1 : 0;
        end else if (pending && mem_ready && lat == mem_delay) begin
            pending <= 1'b0;
            if (mem_write) mem[address[9:2]] <= write_data;
            mem_ready  <= stale_en;
            stale_left <= stale_en ? 2 : 0;
        end else if (pending) begin
            lat       <= lat + 1;
            mem_ready <= !stuck && (lat + 1 == mem_delay);
        end else begin
            mem_ready  <= (stale_left > 0);
            stale_left <= (stale_left > 0) ? stale_left - 1 : 0;
        end
    end

    // ------------------------------------------------------------ scoreboard
    logic [W-1:0] exp_q[$];
    logic [31:0]  ref_mem [logic [31:0]];
    logic [31:0]  last_load;
    logic [31:0]  last_addr;
    int           n_pass  = 0;
    int           n_total = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    task automatic push_exp(bit is_err, bit tmo, int stall_n, logic [31:0] a, logic [31:0] ld);
        exp_q.push_back({is_err, tmo, 8'(stall_n), a, ld});
    endtask

    // ------------------------------------------------------------ monitor
    initial begin : monitor
        int           run;
        bit           prev;
        logic [W-1:0] e;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run  = 0;
                prev = 1'b0;
            end else begin
                if (misalign_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_misalign_event", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("misalign_event_kind", 32'd1, 32'(e[73]));
                        check("misalign_stall", 32'(stall), 32'd0);
                        check("misalign_address_held", address, e[63:32]);
                        check("misalign_load_held", load_data, e[31:0]);
                        check("misalign_mem_write", 32'(mem_write), 32'd0);
                    end
                end
                if (prev && !stall) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_event_kind", 32'd0, 32'(e[73]));
                        check("done_load_data", load_data, e[31:0]);
                        check("done_address", address, e[63:32]);
                        check("done_mem_write", 32'(mem_write), 32'd0);
                        check("done_timeout", 32'(timeout), 32'(e[72]));
                        check("stall_cycles", 32'(run), 32'(e[71:64]));
                    end
                end
                if (stall) run++;
                else run = 0;
                prev = stall;
            end
        end
    end

    // ------------------------------------------------------------ driver tasks
    // Entered just after a rising edge; returns just after the edge that ends
    // the DONE cycle, with the request lines dropped.
    task automatic wait_done(bit chk_wr, logic [31:0] a, logic [31:0] d);
        int cyc;
        bit done;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else if (cyc > 0) begin
                check("wait_mem_write", 32'(mem_write), 32'(chk_wr));
                check("wait_address", address, a);
                if (chk_wr) check("wait_write_data", write_data, d);
            end
            @(posedge clk);
            #1;
            kick = 1'b0;
            cyc++;
        end
        if (!done) check("access_cycle_budget", 32'(cyc), 32'd0);
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic do_access(bit rd, bit wr, logic [31:0] a, logic [31:0] d, int delay, bit stale);
        logic [31:0] exp_load;
        if (wr) begin
            ref_mem[a] = d;
            exp_load   = last_load;
        end else begin
            exp_load  = ref_rd(a);
            last_load = exp_load;
        end
        last_addr = a;
        push_exp(1'b0, 1'b0, delay + 1, a, exp_load);
        mem_delay      = delay;
        stale_en       = stale;
        req_read       = rd;
        req_write      = wr;
        req_address    = a;
        req_write_data = d;
        kick           = 1'b1;
        wait_done(wr, a, d);
    endtask

    task automatic do_misalign(bit rd, bit wr, logic [31:0] a);
        push_exp(1'b1, 1'b0, 0, last_addr, last_load);
        req_read       = rd;
        req_write      = wr;
        req_address    = a;
        req_write_data = $urandom;
        @(posedge clk);
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ------------------------------------------------------------ global guard
    initial begin
        #2000000;
        $display("FAIL global_time_limit: got %0d checks expected completion", n_total);
        $fatal(1, "time limit");
    end

    // ------------------------------------------------------------ stimulus
    initial begin : stim
        int          n_hi;
        int          kind;
        bit          rd;
        bit          wr;
        logic [31:0] a;
        int          wait_cyc;

        rst_n          = 1'b1;
        req_read       = 1'b0;
        req_write      = 1'b0;
        req_address    = 32'd0;
        req_write_data = 32'd0;
        kick           = 1'b0;
        stuck          = 1'b0;
        stale_en       = 1'b0;
        mem_delay      = ND;
        last_load      = 32'd0;
        last_addr      = 32'd0;

        // Reset state and output forcing while reset is held.
        #2 rst_n = 1'b0;
        req_read    = 1'b1;
        req_address = 32'd64;
        #1 check("reset_stall_forced", 32'(stall), 32'd0);
        req_address = 32'd66;
        #1 check("reset_misalign_forced", 32'(misalign_err), 32'd0);
        req_read = 1'b0;
        @(negedge clk);
        check("reset_mem_write", 32'(mem_write), 32'd0);
        check("reset_address", address, 32'd0);
        check("reset_write_data", write_data, 32'd0);
        check("reset_load_data", load_data, 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: write, writes/reads, misaligned, dual request.
        do_access(1'b0, 1'b1, 32'd64, 32'd45, ND, 1'b0);
        idle(1);
        do_access(1'b0, 1'b1, 32'd128, 32'd100, ND, 1'b0);
        do_access(1'b1, 1'b0, 32'd64, 32'd0, ND, 1'b0);
        idle(2);
        do_access(1'b1, 1'b0, 32'd128, 32'd0, ND, 1'b0);
        do_misalign(1'b1, 1'b0, 32'd66);
        idle(1);
        do_access(1'b1, 1'b1, 32'd64, 32'd7, ND, 1'b0);
        do_access(1'b1, 1'b0, 32'd64, 32'd0, ND, 1'b0);

        // Back-to-back with MemReady lingering into the next access's first WAIT.
        do_access(1'b0, 1'b1, 32'd8, 32'd200, ND, 1'b1);
        do_access(1'b1, 1'b0, 32'd8, 32'd0, ND, 1'b1);
        do_access(1'b1, 1'b0, 32'd128, 32'd0, ND + 1, 1'b0);
        idle(3);

        // Reset in the middle of a write's WAIT.
        req_write      = 1'b1;
        req_address    = 32'd64;
        req_write_data = 32'd99;
        kick           = 1'b1;
        @(posedge clk);
        #1;
        kick = 1'b0;
        check("midwait_mem_write", 32'(mem_write), 32'd1);
        check("midwait_address", address, 32'd64);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_mem_write", 32'(mem_write), 32'd0);
        check("midreset_stall", 32'(stall), 32'd0);
        check("midreset_address", address, 32'd0);
        check("midreset_load_data", load_data, 32'd0);
        req_write = 1'b0;
        last_addr = 32'd0;
        last_load = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_access(1'b1, 1'b0, 32'd64, 32'd0, ND, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            a    = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            if (kind == 0) begin
                a[1:0] = 2'($urandom_range(1, 3));
                do_misalign(rd, wr, a);
            end else begin
                do_access(rd, wr, a, $urandom, ND + $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            end
            idle($urandom_range(0, 2));
        end

        // Hung memory.
        stuck = 1'b1;
`ifdef MAU_TIMEOUT_EN
        last_load = 32'hDEADBEEF;
        last_addr = 32'd256;
        push_exp(1'b0, 1'b1, TIMEOUT + 1, 32'd256, 32'hDEADBEEF);
        mem_delay      = 1000;
        stale_en       = 1'b0;
        req_read       = 1'b1;
        req_address    = 32'd256;
        kick           = 1'b1;
        wait_done(1'b0, 32'd256, 32'd0);
        @(negedge clk);
        check("timeout_pulse_width", 32'(timeout), 32'd0);
        @(posedge clk);
        #1;
`else
        mem_delay   = 1000;
        stale_en    = 1'b0;
        req_read    = 1'b1;
        req_address = 32'd256;
        kick        = 1'b1;
        @(posedge clk);
        #1;
        kick = 1'b0;
        n_hi = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (stall && !timeout) n_hi++;
        end
        check("stall_held_without_watchdog", 32'(n_hi), 32'd45);
        #1 rst_n = 1'b0;
        req_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
`endif
        stuck = 1'b0;

        // Drain the scoreboard.
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 50) begin
            @(posedge clk);
            wait_cyc++;
        end
        check("exp_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
